alpharetz_branch_unit: RTL
==========================

Name: alpharetz_branch_unit

Overview:
Flag consumer for the CPU datapath. Accepts a branch request carrying a condition code, and evaluates it against the 8-bit flag register the ALU produces. It then returns taken/not-taken, the resolved next PC, the link address and a mispredict indication. It waits while an ALU flag write is still in flight, with a bounded timeout.

Parameters:
CPU_DATA_WIDTH, 32, PC and address width
OFFSET_WIDTH, 16, signed branch offset width
FLAG_REG_WIDTH, 8, flag register width
INSTR_ALIGN_SHIFT, 2, left shift applied to the sign-extended offset
INSTR_BYTES, 4, added to pc for the link/fall-through address
MAX_WAIT, 15, maximum cycles spent in WAIT_FLAGS before timeout

Ports:
clk  in  1  system clock
async_rst_n  in  1  asynchronous active-low reset
clk_en  in  1  clock enable; the FSM, counter and capture registers advance only when clk_en & sys_en
sys_en  in  1  system enable
flush  in  1  kill the in-flight request
req_valid  in  1  branch request valid
req_ready  out  1  unit can accept a request
cond  in  4  condition code
pred_taken  in  1  front-end prediction
pc  in  CPU_DATA_WIDTH  branch instruction address
offset  in  OFFSET_WIDTH  signed offset
flag_reg  in  FLAG_REG_WIDTH  ALU flags: bit0 Z, bit1 C, bit2 V, bit3 underflow, bit4 half-carry, bit5 N, bit6 parity, bit7 reserved
flags_pending  in  1  an ALU op that writes flag_reg has not yet committed
out_valid  out  1  resolution valid
out_ready  in  1  consumer accepts resolution
taken  out  1  condition true
target_pc  out  CPU_DATA_WIDTH  next PC
link_addr  out  CPU_DATA_WIDTH  pc + INSTR_BYTES
mispredict  out  1  taken != pred_taken
timeout_err  out  1  sticky; set when the wait exceeds MAX_WAIT

Behaviour:
- Reset values (async_rst_n low): state IDLE; req_ready=1; out_valid=0; taken=0; target_pc=0; link_addr=0; mispredict=0; timeout_err=0; wait counter 0.
- Condition codes:
  - 0 AL=1, 1 EQ=Z, 2 NE=!Z, 3 CS=C, 4 CC=!C, 5 MI=N, 6 PL=!N, 7 VS=V, 8 VC=!V
  - 9 LO=C, A HS=!C, B LT=N^V, C GE=!(N^V), D LE=Z|(N^V), E GT=!Z&!(N^V), F NV=0
  - Codes 0 and F are flag-independent.
- States: IDLE, WAIT_FLAGS, DONE. req_ready=1 only in IDLE.
- IDLE, on req_valid & enabled:
  - Capture cond, pred_taken, pc and offset.
  - If the code is flag-dependent and flags_pending=1, go to WAIT_FLAGS and clear the counter.
  - Otherwise evaluate using the current flag_reg, register the outputs and go to DONE.
- Result latency: out_valid rises one cycle after acceptance when no wait is needed.
- WAIT_FLAGS, each enabled cycle:
  - If flags_pending=0: evaluate using the flag_reg sampled that cycle and go to DONE.
  - Else increment the counter.
  - When the counter reaches MAX_WAIT with pending still high: set timeout_err, force taken=0 (fall-through) and go to DONE.
- DONE: out_valid=1, and the outputs stay stable until out_ready, which returns the unit to IDLE on the next edge. No back-to-back acceptance in the same cycle.
- Arithmetic:
  - target_pc = taken ? pc + (sext(offset) << INSTR_ALIGN_SHIFT) : pc + INSTR_BYTES.
  - link_addr = pc + INSTR_BYTES.
  - Both are modulo 2^CPU_DATA_WIDTH; wrap-around is silent.
- mispredict = taken ^ pred_taken. It is registered together with taken.
- flush (synchronous, has priority over all transitions):
  - Go to IDLE and drop out_valid on the next edge.
  - A request presented in the same cycle as flush is not accepted.
  - timeout_err is unaffected.
- clk_en & sys_en low: all state and outputs hold. The counter does not advance.
- async_rst_n asserted mid-operation: outputs return to reset values immediately, without waiting for a clock edge.
- timeout_err clears only on reset.

Test Plan:
- cond=1, flag_reg=8'h01, pc=32'h100, offset=16'h0004, pred_taken=0, pending=0 → next cycle out_valid=1, taken=1, target_pc=32'h110, link_addr=32'h104, mispredict=1.
- cond=B (LT), flag_reg=8'h20 (N=1, V=0) → taken=1. Repeat with flag_reg=8'h24 (N=1, V=1) → taken=0, target_pc=pc+4.
- cond=2, flags_pending high for 3 cycles, then Z=0 on release → out_valid rises exactly one cycle after release, taken=1. cond=0 with pending high → no wait.
- flags_pending stuck high with MAX_WAIT=15 → out_valid after 1+15+1 cycles, taken=0, timeout_err=1 and sticky through the next request.
- pc=32'hFFFF_FFFC, offset=16'h0001, cond=0 → target_pc=32'h0000_0000, link_addr=32'h0000_0000 (wrap). pc=32'h40, offset=16'hFFFF → target_pc=32'h3C.
- out_ready held low for 5 cycles → outputs stable, req_ready=0. flush in WAIT_FLAGS → IDLE next edge, out_valid stays 0. async_rst_n pulse in DONE → out_valid=0 immediately.

Source files
------------

// File: rtl/alpharetz_branch_unit.sv
// Branch resolution unit: evaluates a condition code against the ALU flag register,
// waiting (bounded) while a flag-writing ALU op is still in flight.
module alpharetz_branch_unit #(
  parameter int CPU_DATA_WIDTH    = 32,
  parameter int OFFSET_WIDTH      = 16,
  parameter int FLAG_REG_WIDTH    = 8,
  parameter int INSTR_ALIGN_SHIFT = 2,
  parameter int INSTR_BYTES       = 4,
  parameter int MAX_WAIT          = 15
) (
  input  logic                      clk,
  input  logic                      async_rst_n,
  input  logic                      clk_en,
  input  logic                      sys_en,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [3:0]                cond,
  input  logic                      pred_taken,
  input  logic [CPU_DATA_WIDTH-1:0] pc,
  input  logic [OFFSET_WIDTH-1:0]   offset,
  input  logic [FLAG_REG_WIDTH-1:0] flag_reg,
  input  logic                      flags_pending,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      taken,
  output logic [CPU_DATA_WIDTH-1:0] target_pc,
  output logic [CPU_DATA_WIDTH-1:0] link_addr,
  output logic                      mispredict,
  output logic                      timeout_err
);

  // state      | meaning
  // IDLE       | ready for a branch request
  // WAIT_FLAGS | request captured, waiting for flags_pending to drop
  // DONE       | resolution presented until out_ready
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FLAGS = 2'd1;
  localparam logic [1:0] DONE       = 2'd2;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [1:0]                state;
  logic [CNT_W-1:0]          wait_cnt;
  logic [3:0]                cond_q;
  logic                      pred_q;
  logic [CPU_DATA_WIDTH-1:0] pc_q;
  logic [OFFSET_WIDTH-1:0]   offset_q;

  logic                      en;
  logic [3:0]                eval_cond;
  logic                      eval_pred;
  logic [CPU_DATA_WIDTH-1:0] eval_pc;
  logic [OFFSET_WIDTH-1:0]   eval_off;
  logic [CPU_DATA_WIDTH-1:0] off_sext;
  logic [CPU_DATA_WIDTH-1:0] jump_pc;
  logic [CPU_DATA_WIDTH-1:0] fall_pc;
  logic                      cond_hit;
  logic                      flag_dep;
  logic                      timeout_hit;
  logic                      res_taken;
  logic                      unused_flags;

  assign unused_flags = ^{flag_reg[FLAG_REG_WIDTH-1:6], flag_reg[4:3]};

  function automatic logic cond_true(input logic [3:0] c, input logic [FLAG_REG_WIDTH-1:0] f);
    logic z, cy, v, n;
    z  = f[0];
    cy = f[1];
    v  = f[2];
    n  = f[5];
    case (c)
      4'h0:    cond_true = 1'b1;
      4'h1:    cond_true = z;
      4'h2:    cond_true = !z;
      4'h3:    cond_true = cy;
      4'h4:    cond_true = !cy;
      4'h5:    cond_true = n;
      4'h6:    cond_true = !n;
      4'h7:    cond_true = v;
      4'h8:    cond_true = !v;
      4'h9:    cond_true = cy;
      4'hA:    cond_true = !cy;
      4'hB:    cond_true = n ^ v;
      4'hC:    cond_true = !(n ^ v);
      4'hD:    cond_true = z | (n ^ v);
      4'hE:    cond_true = !z & !(n ^ v);
      default: cond_true = 1'b0;
    endcase
  endfunction

  assign en        = clk_en & sys_en;
  assign req_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  // In IDLE the request is resolved straight from the ports; afterwards from the captured copy.
  assign eval_cond = (state == IDLE) ? cond       : cond_q;
  assign eval_pred = (state == IDLE) ? pred_taken : pred_q;
  assign eval_pc   = (state == IDLE) ? pc         : pc_q;
  assign eval_off  = (state == IDLE) ? offset     : offset_q;

  assign off_sext    = {{(CPU_DATA_WIDTH-OFFSET_WIDTH){eval_off[OFFSET_WIDTH-1]}}, eval_off};
  assign jump_pc     = eval_pc + (off_sext << INSTR_ALIGN_SHIFT);
  assign fall_pc     = eval_pc + CPU_DATA_WIDTH'(INSTR_BYTES);
  assign cond_hit    = cond_true(eval_cond, flag_reg);
  assign flag_dep    = (cond != 4'h0) && (cond != 4'hF);
  assign timeout_hit = (state == WAIT_FLAGS) && flags_pending && (wait_cnt == CNT_W'(MAX_WAIT));
  assign res_taken   = cond_hit & ~timeout_hit;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cond_q      <= '0;
      pred_q      <= 1'b0;
      pc_q        <= '0;
      offset_q    <= '0;
      taken       <= 1'b0;
      target_pc   <= '0;
      link_addr   <= '0;
      mispredict  <= 1'b0;
      timeout_err <= 1'b0;
    end else if (en) begin
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              cond_q   <= cond;
              pred_q   <= pred_taken;
              pc_q     <= pc;
              offset_q <= offset;
              if (flag_dep && flags_pending) begin
                wait_cnt <= '0;
                state    <= WAIT_FLAGS;
              end else begin
                taken      <= res_taken;
                target_pc  <= res_taken ? jump_pc : fall_pc;
                link_addr  <= fall_pc;
                mispredict <= res_taken ^ eval_pred;
                state      <= DONE;
              end
            end
          end
          WAIT_FLAGS: begin
            if (!flags_pending || timeout_hit) begin
              if (timeout_hit) timeout_err <= 1'b1;
              taken      <= res_taken;
              target_pc  <= res_taken ? jump_pc : fall_pc;
              link_addr  <= fall_pc;
              mispredict <= res_taken ^ eval_pred;
              state      <= DONE;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          DONE: begin
            if (out_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
